// File: rtl/data_mem_resp.sv
// Memory-side responder for the core data port: granted load/store into a byte-enabled word RAM, one outstanding op.
// Latency: gnt WAIT_CYCLES cycles after req is seen idle (same cycle when 0), rvalid one cycle after gnt. Optional DMEM_RANGE_CHECK_EN adds data_err_o.
// Backpressure: the initiator holds req and its fields until gnt; dropping req before gnt abandons the request without a response.
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        core_clk,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic [31:0] data_add_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    input  logic [4:0]  rd_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [4:0]  rd_o
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic        data_err_o
`endif
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic          w_gnt;
    logic [31:0]   r_rdata;
    logic [4:0]    r_rd;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_unused;

    assign w_off    = data_add_i - BASE_ADDR;
    assign w_idx    = w_off[AW+1:2];
    assign w_unused = ^w_off;

`ifdef DMEM_RANGE_CHECK_EN
    // Addresses below BASE_ADDR wrap to huge offsets and fail the same compare.
    assign w_in_range = (w_off[31:2] < 30'(DEPTH_WORDS));
`else
    assign w_in_range = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (data_req_i) begin
                    if (NO_WAIT) begin
                        w_gnt       = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = WAIT_INIT;
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!data_req_i) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_gnt       = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_rd    <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_gnt) begin
                r_rd <= rd_i;
                if (data_we_i || !w_in_range) begin
                    r_rdata <= 32'd0;
                end else begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // RAM is deliberately not reset; only granted in-range stores touch it.
    always_ff @(posedge core_clk) begin
        if (w_gnt && data_we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic r_err;

    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_gnt) begin
            r_err <= !w_in_range;
        end
    end

    assign data_err_o = r_err;
`endif

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = (r_state == ST_RESP);
    assign data_rdata_o  = r_rdata;
    assign rd_o          = r_rd;

endmodule
